// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment scan driver with per-frame digit snapshot and dash rendering of nibbles 10-15.
// Optional leading-zero blanking is compiled in when LEADING_ZERO_BLANK_EN is defined.
module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]        r_pre;
  logic [IW-1:0]        r_idx;
  logic [4*DIGITS-1:0]  r_snap_d;
  logic [DIGITS-1:0]    r_snap_dp;

  logic                 w_pre_wrap;
  logic                 w_idx_wrap;
  logic                 w_frame_start;
  logic [3:0]           w_cur_digit;
  logic                 w_cur_dp;
  logic                 w_lz_blank;
  logic                 w_lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    w_pre_wrap    = (r_pre == PRE_LAST);
    w_idx_wrap    = (r_idx == IDX_LAST);
    w_frame_start = en && (r_pre == '0) && (r_idx == '0);
    w_cur_digit   = 4'd0;
    w_cur_dp      = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_cur_digit = r_snap_d[4*k +: 4];
        w_cur_dp    = r_snap_dp[k];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit is blank only while every digit above it is a bare zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    w_lz_blank = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run && (r_snap_d[4*k +: 4] == 4'd0) && !r_snap_dp[k];
      if ((k != 0) && (r_idx == IW'(k))) begin
        w_lz_blank = run;
      end
    end
  end
`else
  always_comb begin
    w_lz_blank = 1'b0;
  end
`endif

  // The first cycle of each slot stays dark so the anode switch never shows the previous digit's segments.
  always_comb begin
    w_lit = en && (r_pre != '0) && !w_lz_blank;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre     <= '0;
      r_idx     <= '0;
      r_snap_d  <= '0;
      r_snap_dp <= '0;
    end else if (en) begin
      if (w_frame_start) begin
        r_snap_d  <= digits_in;
        r_snap_dp <= dp_in;
      end
      if (w_pre_wrap) begin
        r_pre <= '0;
        r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= en && w_idx_wrap && w_pre_wrap;
      if (w_lit) begin
        seg_n <= seg_decode(w_cur_digit);
        dp_n  <= ~w_cur_dp;
        an_n  <= ~(DIGITS'(1) << r_idx);
      end else begin
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
        an_n  <= '1;
      end
    end
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Multiplexed 7-segment display driver that consumes the 4-bit digit outputs of a cascade of BCD counter stages and time-multiplexes them onto one shared segment bus with per-digit anode selects. It sits directly downstream of the counter chain. It snapshots all digits at each frame start so the display never tears while the counters run. It also renders out-of-range nibbles (10–15) as a dash.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned; must be at least 1.
- PRESCALE, 1000: clk cycles per digit slot; must be at least 2.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- rstn, input, 1: asynchronous, active-low reset.
- en, input, 1: scan enable. When low, the scan freezes and the display blanks.
- digits_in, input, 4*DIGITS: digit k is digits_in[4k+3:4k]; digit 0 is least significant.
- dp_in, input, DIGITS: decimal point request per digit.
- seg_n, output, 7: active-low segments, bit order {g,f,e,d,c,b,a}.
- dp_n, output, 1: active-low decimal point.
- an_n, output, DIGITS: active-low digit select; at most one bit is low at any time.
- frame_done, output, 1: one-cycle pulse at the end of each full scan.

## Operation
- State:
  - prescaler pre, counting 0..PRESCALE-1.
  - digit index idx, counting 0..DIGITS-1.
  - snapshot registers snap_d (4*DIGITS bits) and snap_dp (DIGITS bits).
  - registered outputs.
- With en high:
  - pre increments each cycle.
  - When pre = PRESCALE-1, pre wraps to 0 and idx advances, wrapping DIGITS-1 to 0.
- With en low: pre, idx and the snapshot hold. Outputs are forced blank: an_n all 1, seg_n all 1, dp_n 1.
- Frame start is any cycle with en=1, pre=0 and idx=0. On that cycle snap_d ← digits_in and snap_dp ← dp_in. Between frame starts the snapshot is stable.
- Dead time: during the slot's first cycle (pre=0) the outputs are blank. This prevents ghosting between digits.
- For pre ≠ 0, the outputs are:
  - an_n: bit idx low, all other bits high.
  - seg_n: the decode of snap digit idx.
  - dp_n: ~snap_dp[idx].
- Segment decode (seg_n):
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - 10–15: 0111111 (g only, a dash)
- frame_done = 1 for one cycle, following any cycle with en=1, idx=DIGITS-1 and pre=PRESCALE-1.
- Reset mid-operation: all state clears immediately and asynchronously. Scanning restarts at idx 0, pre 0. The first enabled cycle after reset is a frame start.

## Timing
- All outputs are registered. The outputs in cycle t+1 reflect pre, idx, snapshot and en as they stand in cycle t.
- Slot length is PRESCALE cycles, of which 1 is blank and PRESCALE-1 are lit. Frame length is DIGITS*PRESCALE cycles.
- A digits_in change shows up at the next frame start. The worst-case latency to appear on the digit's slot is 2*DIGITS*PRESCALE cycles.
- en falling: the display blanks on the next cycle. en rising: the scan resumes from the held pre and idx with no extra delay.
- Reset values: an_n all 1, seg_n 1111111, dp_n 1, frame_done 0; internally pre 0, idx 0, snap_d 0, snap_dp 0.

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- When defined, leading-zero blanking is compiled in:
  - Digit k (k ≥ 1) is blanked (an_n all 1 during its slot) when snap_d digit k and every higher digit are 0, and none of those digits has its snap_dp bit set.
  - Digit 0 is never blanked.
  - Blanking is evaluated from the snapshot.
- When undefined, every digit is always displayed, including leading zeros.

## Test plan
- Reset values: assert rstn=0 mid-slot. Required: an_n=1111, seg_n=1111111, dp_n=1, frame_done=0 asynchronously, before the next clk edge.
- Basic scan: DIGITS=4, PRESCALE=4, en=1, digits_in=16'h1234, dp_in=0100. Required:
  - Slot 0: one blank cycle, then 3 cycles with an_n=1110, seg_n=0011001.
  - Slot 2: an_n=1011, seg_n=0100100, dp_n=0.
  - frame_done pulses once every 16 cycles.
- Snapshot: change digits_in from 16'h1234 to 16'h5678 during slot 2. Required: the rest of the frame still shows 1,2. The next frame shows 8,7,6,5.
- Invalid nibble: digits_in=16'h00F0. Required: slot 1 shows seg_n=0111111.
- en control: drop en for 10 cycles in slot 1, pre=2. Required: blank outputs, no frame_done. After en returns, slot 1 finishes its remaining lit cycles.
- Leading-zero blanking (macro defined): digits_in=16'h0050, dp_in=0000. Required: slots 3 and 2 are blank (an_n=1111), slot 1 shows 5, slot 0 shows 0. With dp_in=1000, slot 3 shows 0 with dp_n=0.
